// File: rtl/fpnew_pkg.sv
// Shared types and helpers for the sequential lane slice.
// Used by fpnew_lane_seq_slice and fpnew_lane_seq_buffer.
package fpnew_pkg;

  localparam int STATUS_W = 5;

  typedef enum logic [1:0] {
    IDLE,
    ACTIVE,
    DONE
  } seq_state_e;

  function automatic int num_beats(int w, int f, int u);
    return ((w / f) + u - 1) / u;
  endfunction

endpackage

// File: rtl/fpnew_lane_seq_buffer.sv
// Result/status assembly buffer for the sequential lane slice.
// Unused lanes of a scalar op are filled with the captured ext bit.
module fpnew_lane_seq_buffer
  import fpnew_pkg::*;
#(
  parameter int Width    = 64,
  parameter int FpWidth  = 16,
  parameter int NumUnits = 2,
  parameter int CW       = 2
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic                          clr_i,
  input  logic                          wr_i,
  input  logic [CW-1:0]                 beat_i,
  input  logic [NumUnits-1:0]           act_i,
  input  logic                          vec_i,
  input  logic [NumUnits*FpWidth-1:0]   res_i,
  input  logic [NumUnits*STATUS_W-1:0]  status_i,
  input  logic                          ext_i,
  output logic [Width-1:0]              result_o,
  output logic [STATUS_W-1:0]           status_o,
  output logic                          ext_o
);

  localparam int NL = Width / FpWidth;

  logic [Width-1:0]    slot_q;
  logic [STATUS_W-1:0] st_q, st_d;
  logic                ext_q;

  always_comb begin
    st_d = st_q;
    for (int u = 0; u < NumUnits; u++) begin
      if (act_i[u]) st_d = st_d | status_i[u*STATUS_W +: STATUS_W];
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni || clr_i) begin
      slot_q <= '0;
      st_q   <= '0;
      ext_q  <= 1'b0;
    end else if (wr_i) begin
      st_q <= st_d;
      for (int l = 0; l < NL; l++) begin
        if ((l / NumUnits) == int'(beat_i) && act_i[l % NumUnits])
          slot_q[l*FpWidth +: FpWidth] <=
            res_i[(l % NumUnits)*FpWidth +: FpWidth];
      end
      if (beat_i == '0) ext_q <= ext_i;
    end
  end

  // scalar ops NaN-box / sign-extend through the upper lanes
  always_comb begin
    result_o = '0;
    for (int l = 0; l < NL; l++) begin
      if (vec_i || l == 0)
        result_o[l*FpWidth +: FpWidth] = slot_q[l*FpWidth +: FpWidth];
      else
        result_o[l*FpWidth +: FpWidth] = {FpWidth{ext_q}};
    end
  end

  assign status_o = st_q;
  assign ext_o    = ext_q;

endmodule

// File: rtl/fpnew_lane_seq_slice.sv
// Time-multiplexed FP format slice: NUM_LANES lanes over NumUnits units.
// FPNEW_SEQ_OVERLAP_EN lets beats issue while collection lags.
module fpnew_lane_seq_slice
  import fpnew_pkg::*;
#(
  parameter int Width       = 64,
  parameter int FpWidth     = 16,
  parameter int NumUnits    = 2,
  parameter int NumOperands = 3,
  parameter int TagWidth    = 2
) (
  input  logic                                 clk_i,
  input  logic                                 rst_ni,
  input  logic [NumOperands*Width-1:0]         operands_i,
  input  logic                                 vectorial_op_i,
  input  logic [TagWidth-1:0]                  tag_i,
  input  logic                                 in_valid_i,
  output logic                                 in_ready_o,
  input  logic                                 flush_i,
  output logic [NumUnits*NumOperands*FpWidth-1:0] unit_operands_o,
  output logic [NumUnits-1:0]                  unit_valid_o,
  input  logic [NumUnits-1:0]                  unit_ready_i,
  input  logic [NumUnits*FpWidth-1:0]          unit_result_i,
  input  logic [NumUnits*STATUS_W-1:0]         unit_status_i,
  input  logic [NumUnits-1:0]                  unit_ext_bit_i,
  input  logic [NumUnits-1:0]                  unit_out_valid_i,
  output logic [NumUnits-1:0]                  unit_out_ready_o,
  output logic                                 unit_flush_o,
  output logic [Width-1:0]                     result_o,
  output logic [STATUS_W-1:0]                  status_o,
  output logic                                 extension_bit_o,
  output logic [TagWidth-1:0]                  tag_o,
  output logic                                 out_valid_o,
  input  logic                                 out_ready_i,
  output logic                                 busy_o
);

  localparam int NL = Width / FpWidth;
  localparam int NB = num_beats(Width, FpWidth, NumUnits);
  localparam int CW = $clog2(NB + 1);
  localparam int OW = NumOperands * Width;

  seq_state_e              state_q, state_d;
  logic [CW-1:0]           iss_q, iss_d, col_q, col_d;
  logic [OW-1:0]           ops_q;
  logic                    vec_q;
  logic [TagWidth-1:0]     tag_q;
  logic [CW-1:0]           beats;
  logic [NumUnits-1:0]     iss_act, col_act;
  logic                    accept, can_iss, iss_fire, col_en, col_fire;
  logic                    unused_ext;

  assign beats  = vec_q ? CW'(NB) : CW'(1);
  assign accept = (state_q == IDLE) && in_valid_i && !flush_i;

  always_comb begin
    int li, lc;
    li = 0;
    lc = 0;
    iss_act = '0;
    col_act = '0;
    for (int u = 0; u < NumUnits; u++) begin
      li = int'(iss_q) * NumUnits + u;
      lc = int'(col_q) * NumUnits + u;
      iss_act[u] = (li < NL) && (vec_q || li == 0);
      col_act[u] = (lc < NL) && (vec_q || lc == 0);
    end
  end

`ifdef FPNEW_SEQ_OVERLAP_EN
  assign can_iss = (state_q == ACTIVE) && (iss_q < beats);
`else
  assign can_iss = (state_q == ACTIVE) && (iss_q < beats) && (iss_q == col_q);
`endif

  // all active lanes of a beat leave together
  assign iss_fire = can_iss && !flush_i && (&(unit_ready_i | ~iss_act));
  assign unit_valid_o = iss_fire ? iss_act : '0;

  assign col_en   = (state_q == ACTIVE) && (col_q < iss_q);
  assign col_fire = col_en && !flush_i && (&(unit_out_valid_i | ~col_act));
  assign unit_out_ready_o = col_en ? col_act : '0;

  always_comb begin
    int li;
    li = 0;
    unit_operands_o = '0;
    for (int u = 0; u < NumUnits; u++) begin
      li = int'(iss_q) * NumUnits + u;
      if (li < NL) begin
        for (int o = 0; o < NumOperands; o++)
          unit_operands_o[(u*NumOperands+o)*FpWidth +: FpWidth] =
            ops_q[o*Width + li*FpWidth +: FpWidth];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    iss_d   = iss_q;
    col_d   = col_q;
    if (flush_i) begin
      state_d = IDLE;
      iss_d   = '0;
      col_d   = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid_i) begin
            state_d = ACTIVE;
            iss_d   = '0;
            col_d   = '0;
          end
        end
        ACTIVE: begin
          if (iss_fire) iss_d = iss_q + CW'(1);
          if (col_fire) begin
            col_d = col_q + CW'(1);
            if (col_q + CW'(1) == beats) state_d = DONE;
          end
        end
        DONE: begin
          if (out_ready_i) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      iss_q   <= '0;
      col_q   <= '0;
      ops_q   <= '0;
      vec_q   <= 1'b0;
      tag_q   <= '0;
    end else begin
      state_q <= state_d;
      iss_q   <= iss_d;
      col_q   <= col_d;
      if (accept) begin
        ops_q <= operands_i;
        vec_q <= vectorial_op_i;
        tag_q <= tag_i;
      end
    end
  end

  fpnew_lane_seq_buffer #(
    .Width   (Width),
    .FpWidth (FpWidth),
    .NumUnits(NumUnits),
    .CW      (CW)
  ) i_buf (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .clr_i   (accept || flush_i),
    .wr_i    (col_fire),
    .beat_i  (col_q),
    .act_i   (col_act),
    .vec_i   (vec_q),
    .res_i   (unit_result_i),
    .status_i(unit_status_i),
    .ext_i   (unit_ext_bit_i[0]),
    .result_o(result_o),
    .status_o(status_o),
    .ext_o   (extension_bit_o)
  );

  assign unused_ext   = ^unit_ext_bit_i;
  assign in_ready_o   = (state_q == IDLE);
  assign out_valid_o  = (state_q == DONE);
  assign busy_o       = (state_q != IDLE);
  assign tag_o        = tag_q;
  assign unit_flush_o = flush_i;

endmodule

// File: tb/tb_fpnew_lane_seq_slice.sv
// Bench for fpnew_lane_seq_slice: 2-unit and 3-unit instances with
// single-cycle unit models (result=a, status=b[4:0], ext=c[0]).
module tb_fpnew_lane_seq_slice;

  typedef struct {
    logic [63:0] r;
    logic [4:0]  s;
    logic [1:0]  t;
    logic        e;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [191:0] ops;
  logic         vec;
  logic [1:0]   tag;
  logic         in_valid, in_ready, flush;
  logic [95:0]  uops;
  logic [1:0]   uv, ur, uov, uor, uext;
  logic [31:0]  ures;
  logic [9:0]   ust;
  logic         uflush;
  logic [63:0]  res;
  logic [4:0]   st;
  logic         ext;
  logic [1:0]   tago;
  logic         out_valid, out_ready, busy;

  logic         in_valid3, in_ready3, out_ready3, out_valid3, busy3;
  logic [143:0] uops3;
  logic [2:0]   uv3, ur3, uov3, uor3, uext3;
  logic [47:0]  ures3;
  logic [14:0]  ust3;
  logic         uflush3, ext3;
  logic [63:0]  res3;
  logic [4:0]   st3;
  logic [1:0]   tago3;

  fpnew_lane_seq_slice dut (
    .clk_i(clk), .rst_ni(rst_n), .operands_i(ops),
    .vectorial_op_i(vec), .tag_i(tag),
    .in_valid_i(in_valid), .in_ready_o(in_ready), .flush_i(flush),
    .unit_operands_o(uops), .unit_valid_o(uv), .unit_ready_i(ur),
    .unit_result_i(ures), .unit_status_i(ust),
    .unit_ext_bit_i(uext), .unit_out_valid_i(uov),
    .unit_out_ready_o(uor), .unit_flush_o(uflush),
    .result_o(res), .status_o(st), .extension_bit_o(ext),
    .tag_o(tago), .out_valid_o(out_valid),
    .out_ready_i(out_ready), .busy_o(busy)
  );

  fpnew_lane_seq_slice #(.NumUnits(3)) dut3 (
    .clk_i(clk), .rst_ni(rst_n), .operands_i(ops),
    .vectorial_op_i(vec), .tag_i(tag),
    .in_valid_i(in_valid3), .in_ready_o(in_ready3), .flush_i(flush),
    .unit_operands_o(uops3), .unit_valid_o(uv3), .unit_ready_i(ur3),
    .unit_result_i(ures3), .unit_status_i(ust3),
    .unit_ext_bit_i(uext3), .unit_out_valid_i(uov3),
    .unit_out_ready_o(uor3), .unit_flush_o(uflush3),
    .result_o(res3), .status_o(st3), .extension_bit_o(ext3),
    .tag_o(tago3), .out_valid_o(out_valid3),
    .out_ready_i(out_ready3), .busy_o(busy3)
  );

  // single-cycle unit models
  logic [1:0]  m_ov;
  logic [15:0] m_r[2];
  logic [4:0]  m_s[2];
  logic        m_e[2];
  int          fire[2];
  assign ur   = ~m_ov | uor;
  assign uov  = m_ov;
  assign ures = {m_r[1], m_r[0]};
  assign ust  = {m_s[1], m_s[0]};
  assign uext = {m_e[1], m_e[0]};

  always @(posedge clk) begin
    for (int u = 0; u < 2; u++) begin
      if (!rst_n || uflush) m_ov[u] <= 1'b0;
      else if (uv[u] && ur[u]) begin
        m_ov[u] <= 1'b1;
        m_r[u]  <= uops[(u*3+0)*16 +: 16];
        m_s[u]  <= uops[(u*3+1)*16 +: 5];
        m_e[u]  <= uops[(u*3+2)*16];
        fire[u] <= fire[u] + 1;
      end else if (m_ov[u] && uor[u]) m_ov[u] <= 1'b0;
    end
  end

  logic [2:0]  m3_ov;
  logic [15:0] m3_r[3];
  logic [4:0]  m3_s[3];
  logic        m3_e[3];
  int          fire3[3];
  assign ur3   = ~m3_ov | uor3;
  assign uov3  = m3_ov;
  assign ures3 = {m3_r[2], m3_r[1], m3_r[0]};
  assign ust3  = {m3_s[2], m3_s[1], m3_s[0]};
  assign uext3 = {m3_e[2], m3_e[1], m3_e[0]};

  always @(posedge clk) begin
    for (int u = 0; u < 3; u++) begin
      if (!rst_n || uflush3) m3_ov[u] <= 1'b0;
      else if (uv3[u] && ur3[u]) begin
        m3_ov[u] <= 1'b1;
        m3_r[u]  <= uops3[(u*3+0)*16 +: 16];
        m3_s[u]  <= uops3[(u*3+1)*16 +: 5];
        m3_e[u]  <= uops3[(u*3+2)*16];
        fire3[u] <= fire3[u] + 1;
      end else if (m3_ov[u] && uor3[u]) m3_ov[u] <= 1'b0;
    end
  end

  exp_t sb[$];
  exp_t sb3[$];
  int   n_chk = 0;
  int   n_pass = 0;

  function automatic exp_t model(input logic [63:0] a, b, c,
                                 input logic v, input logic [1:0] t);
    exp_t x;
    x.r = '0;
    x.s = '0;
    x.t = t;
    x.e = c[0];
    for (int l = 0; l < 4; l++) begin
      if (v || l == 0) begin
        x.r[l*16 +: 16] = a[l*16 +: 16];
        x.s = x.s | b[l*16 +: 5];
      end else begin
        x.r[l*16 +: 16] = {16{c[0]}};
      end
    end
    return x;
  endfunction

  task automatic send(input logic [63:0] a, b, c, input logic v,
                      input logic [1:0] t, input bit push);
    int k;
    k = 0;
    @(negedge clk);
    ops = {c, b, a};
    vec = v;
    tag = t;
    in_valid = 1'b1;
    while (!in_ready && k < 50) begin
      @(negedge clk);
      k++;
    end
    if (k >= 50) begin
      n_chk++;
      $display("FAIL accept_timeout in_ready=%b want 1", in_ready);
    end else if (push) begin
      sb.push_back(model(a, b, c, v, t));
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic collect(input int hold);
    exp_t x;
    logic [63:0] r0;
    logic [1:0]  t0;
    int k;
    k = 0;
    while (!out_valid && k < 100) begin
      @(negedge clk);
      k++;
    end
    n_chk++;
    if (k >= 100) begin
      $display("FAIL out_timeout out_valid=%b want 1", out_valid);
      return;
    end else if (sb.size() == 0) begin
      $display("FAIL sb_empty size=0 want >0");
      return;
    end
    n_pass++;
    x = sb.pop_front();
    n_chk++;
    if (res !== x.r) $display("FAIL result got %h want %h", res, x.r);
    else n_pass++;
    n_chk++;
    if (st !== x.s) $display("FAIL status got %b want %b", st, x.s);
    else n_pass++;
    n_chk++;
    if (tago !== x.t) $display("FAIL tag got %0d want %0d", tago, x.t);
    else n_pass++;
    n_chk++;
    if (ext !== x.e) $display("FAIL ext got %b want %b", ext, x.e);
    else n_pass++;
    r0 = res;
    t0 = tago;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      n_chk++;
      if (res !== r0 || tago !== t0 || in_ready !== 1'b0 ||
          out_valid !== 1'b1)
        $display("FAIL hold%0d res=%h tag=%0d rdy=%b ov=%b want %h %0d 0 1",
                 i, res, tago, in_ready, out_valid, r0, t0);
      else n_pass++;
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    n_chk++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1)
      $display("FAIL reset_ctrl ov=%b busy=%b rdy=%b want 0 0 1",
               out_valid, busy, in_ready);
    else n_pass++;
    n_chk++;
    if (res !== 64'h0 || st !== 5'h0 || tago !== 2'h0 || ext !== 1'b0)
      $display("FAIL reset_data res=%h st=%b tag=%0d ext=%b want 0",
               res, st, tago, ext);
    else n_pass++;
  endtask

  task automatic test_vector();
    int f0;
    f0 = fire[0];
    send(64'h0003_0002_0001_0000, 64'h0, 64'h0, 1'b1, 2'd2, 1'b1);
    collect(0);
    n_chk++;
    if (fire[0] - f0 !== 2) $display("FAIL vec_beats got %0d want 2", fire[0] - f0);
    else n_pass++;
  endtask

  task automatic test_scalar();
    int f1;
    f1 = fire[1];
    send(64'h1234_5678_9ABC_3C00, 64'h1F1F_1F1F_1F1F_0000,
         64'h0000_0000_0000_0001, 1'b0, 2'd1, 1'b1);
    collect(0);
    n_chk++;
    if (fire[1] !== f1) $display("FAIL scalar_u1 got %0d want %0d", fire[1], f1);
    else n_pass++;
  endtask

  task automatic test_status();
    send(64'h0004_0003_0002_0001, 64'h0004_0001_0000_0000, 64'h0,
         1'b1, 2'd3, 1'b1);
    collect(0);
    send(64'h0008_0007_0006_0005, 64'h0, 64'h0, 1'b1, 2'd0, 1'b1);
    collect(0);
  endtask

  task automatic test_flush();
    bit seen;
    seen = 1'b0;
    send(64'hAAAA_BBBB_CCCC_DDDD, 64'h0, 64'h0, 1'b1, 2'd1, 1'b0);
    @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    n_chk++;
    if (busy !== 1'b0 || out_valid !== 1'b0 || in_ready !== 1'b1)
      $display("FAIL flush_idle busy=%b ov=%b rdy=%b want 0 0 1",
               busy, out_valid, in_ready);
    else n_pass++;
    repeat (8) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
    end
    n_chk++;
    if (seen !== 1'b0) $display("FAIL flush_nov got %b want 0", seen);
    else n_pass++;
    send(64'h0040_0030_0020_0010, 64'h0000_0000_0010_0000, 64'h0,
         1'b1, 2'd2, 1'b1);
    collect(0);
  endtask

  task automatic test_accept_flush();
    @(negedge clk);
    ops = '1;
    vec = 1'b1;
    in_valid = 1'b1;
    flush = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    flush = 1'b0;
    n_chk++;
    if (busy !== 1'b0 || in_ready !== 1'b1)
      $display("FAIL acc_flush busy=%b rdy=%b want 0 1", busy, in_ready);
    else n_pass++;
  endtask

  task automatic test_hold();
    send(64'h5555_6666_7777_8888, 64'h0002_0000_0000_0000, 64'h0,
         1'b1, 2'd3, 1'b1);
    collect(5);
  endtask

  task automatic test_three_units();
    exp_t x;
    int f0, f1, f2, k;
    f0 = fire3[0];
    f1 = fire3[1];
    f2 = fire3[2];
    @(negedge clk);
    ops = {64'h0, 64'h0, 64'h0013_0012_0011_0010};
    vec = 1'b1;
    tag = 2'd1;
    in_valid3 = 1'b1;
    sb3.push_back(model(64'h0013_0012_0011_0010, 64'h0, 64'h0, 1'b1, 2'd1));
    @(negedge clk);
    in_valid3 = 1'b0;
    k = 0;
    while (!out_valid3 && k < 100) begin
      @(negedge clk);
      k++;
    end
    n_chk++;
    if (k >= 100) $display("FAIL u3_timeout out_valid=%b want 1", out_valid3);
    else n_pass++;
    x = sb3.pop_front();
    n_chk++;
    if (res3 !== x.r || tago3 !== x.t)
      $display("FAIL u3_result got %h/%0d want %h/%0d", res3, tago3, x.r, x.t);
    else n_pass++;
    n_chk++;
    if (fire3[0] - f0 !== 2 || fire3[1] - f1 !== 1 || fire3[2] - f2 !== 1)
      $display("FAIL u3_issues got %0d %0d %0d want 2 1 1",
               fire3[0] - f0, fire3[1] - f1, fire3[2] - f2);
    else n_pass++;
    out_ready3 = 1'b1;
    @(negedge clk);
    out_ready3 = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    ops = '0;
    vec = 1'b0;
    tag = '0;
    in_valid = 1'b0;
    flush = 1'b0;
    out_ready = 1'b0;
    in_valid3 = 1'b0;
    out_ready3 = 1'b0;
    test_reset();
    test_vector();
    test_scalar();
    test_status();
    test_flush();
    test_accept_flush();
    test_hold();
    test_three_units();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
